md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS core.
- Sits downstream of the instruction decoder and consumes its decoded multiply/divide operation code together with the E-stage rs/rt operands.
- Owns the HI/LO registers and reports Busy. The hazard unit uses Busy to stall the D stage on mfhi/mflo/mult/div while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy is held for mult/multu (and madd/maddu); legal range 1..15.
- DIV_CYCLES, 10, cycles Busy is held for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- MDOp  input  4  decoded op: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, others none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Single clock domain. Reset is synchronous and active-high: at a rising clk edge with reset=1, HI=0, LO=0, Busy=0, counter=0, and any pending result is discarded.
- Two states. State is IDLE when counter==0 and BUSY otherwise. Busy is registered and equals (counter!=0).
- IDLE, MDOp in {mult, multu, madd, maddu, div, divu} at edge k:
  - Compute the result from A/B and latch it into internal pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from edge k to edge k+N, i.e. exactly N cycles high.
- BUSY:
  - The counter decrements each edge.
  - At the edge where the counter goes 1->0, the pending result is written to HI/LO and Busy drops in the same edge.
  - HI/LO keep their old values throughout BUSY.
- mthi/mtlo in IDLE: HI=A (or LO=A) at the next edge. Busy stays 0 and the counter is untouched.
- Any non-none MDOp while BUSY is ignored, including mthi/mtlo and new starts. The in-flight op is unaffected. Correct stalling is the hazard unit's job.
- mult: {HI,LO} = signed(A) * signed(B), 64-bit.
- multu: {HI,LO} = unsigned(A) * unsigned(B), 64-bit.
- div:
  - LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (div or divu with B==0): Busy still runs DIV_CYCLES, and HI/LO are left unchanged at commit.
- Reset in any cycle aborts the operation; no late commit occurs.
- MDOp of none or an unused code: no state change.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - madd: {HI,LO} = {HI,LO} + signed(A)*signed(B), mod 2^64.
  - maddu: same with the product unsigned.
  - Both use MULT_CYCLES.
  - The accumulate base is the HI/LO value at issue; HI/LO cannot change while BUSY, so this equals the value at commit.
- Undefined: codes 0111 and 1000 are treated as none. No accumulator logic is built.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> Busy high exactly 5 cycles; at the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 -> HI/LO updated one edge each, Busy never asserted. Then divu A=5 B=0 -> Busy 10 cycles, HI=0x12345678, LO=0x9ABCDEF0 unchanged.
- mult A=3 B=4 issued; during Busy drive mtlo A=0xDEADBEEF and divu A=9 B=2 -> both ignored; after 5 cycles HI=0, LO=12; Busy low exactly 5 cycles after issue.
- mult A=3 B=4, assert reset on the 3rd Busy cycle -> next edge Busy=0, HI=LO=0; remains 0 for 10 further cycles with MDOp=none.
- With MD_MADD_EN: mthi 0, mtlo 0xFFFFFFFF, then maddu A=1 B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same sequence leaves HI=0, LO=0xFFFFFFFF and Busy stays 0.

Source files
------------

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and holds Busy for a fixed latency per op.
// Optional MD_MADD_EN macro adds madd/maddu (accumulate into {HI,LO}).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
`endif

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    function automatic logic [2*DATA_W-1:0] mul_signed(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] ax;
        logic signed [2*DATA_W-1:0] bx;
        ax = (2*DATA_W)'(a);
        bx = (2*DATA_W)'(b);
        return ax * bx;
    endfunction

    function automatic logic [2*DATA_W-1:0] mul_unsigned(input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] ax;
        logic [2*DATA_W-1:0] bx;
        ax = {{DATA_W{1'b0}}, a};
        bx = {{DATA_W{1'b0}}, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; divisor must be nonzero.
    function automatic logic [2*DATA_W-1:0] div_unsigned(input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    // Divides on magnitudes so MIN / -1 wraps to MIN instead of overflowing.
    function automatic logic [2*DATA_W-1:0] div_signed(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        logic [DATA_W-1:0]   ua;
        logic [DATA_W-1:0]   ub;
        logic [2*DATA_W-1:0] rq;
        logic [DATA_W-1:0]   q;
        logic [DATA_W-1:0]   r;
        ua = a[DATA_W-1] ? (~a + 1'b1) : a;
        ub = b[DATA_W-1] ? (~b + 1'b1) : b;
        rq = div_unsigned(ua, ub);
        q  = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~rq[DATA_W-1:0] + 1'b1) : rq[DATA_W-1:0];
        r  = a[DATA_W-1] ? (~rq[2*DATA_W-1:DATA_W] + 1'b1) : rq[2*DATA_W-1:DATA_W];
        return {r, q};
    endfunction

    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [CNT_W-1:0]    load_val;
    logic                idle;
    logic                start;
    logic                commit;
    logic [2*DATA_W-1:0] pend;
    logic                pend_wr;
    logic [2*DATA_W-1:0] res_nxt;
    logic                wr_nxt;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   hi_nxt;
    logic [DATA_W-1:0]   lo_nxt;

    assign idle    = (count == '0);
    assign divisor = (B == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : B;

    // Operation decode and result computation at issue
    always_comb begin
        start    = 1'b0;
        load_val = '0;
        res_nxt  = pend;
        wr_nxt   = pend_wr;
        if (idle) begin
            case (MDOp)
                OP_MULT: begin
                    start = 1'b1; load_val = MULT_LOAD; wr_nxt = 1'b1;
                    res_nxt = mul_signed(A, B);
                end
                OP_MULTU: begin
                    start = 1'b1; load_val = MULT_LOAD; wr_nxt = 1'b1;
                    res_nxt = mul_unsigned(A, B);
                end
                OP_DIV: begin
                    start = 1'b1; load_val = DIV_LOAD; wr_nxt = (B != '0);
                    res_nxt = div_signed(A, divisor);
                end
                OP_DIVU: begin
                    start = 1'b1; load_val = DIV_LOAD; wr_nxt = (B != '0);
                    res_nxt = div_unsigned(A, divisor);
                end
`ifdef MD_MADD_EN
                OP_MADD: begin
                    start = 1'b1; load_val = MULT_LOAD; wr_nxt = 1'b1;
                    res_nxt = {HI, LO} + mul_signed(A, B);
                end
                OP_MADDU: begin
                    start = 1'b1; load_val = MULT_LOAD; wr_nxt = 1'b1;
                    res_nxt = {HI, LO} + mul_unsigned(A, B);
                end
`endif
                default: begin
                    start = 1'b0;
                end
            endcase
        end
    end

    // Next-state: counter load on issue, decrement while busy
    always_comb begin
        count_nxt = count;
        commit    = 1'b0;
        if (idle) begin
            if (start) count_nxt = load_val;
        end else begin
            count_nxt = count - 1'b1;
            commit    = (count == {{(CNT_W-1){1'b0}}, 1'b1});
        end
    end

    // Output: HI/LO update from commit or move-to in idle
    always_comb begin
        hi_nxt = HI;
        lo_nxt = LO;
        if (commit && pend_wr) begin
            hi_nxt = pend[2*DATA_W-1:DATA_W];
            lo_nxt = pend[DATA_W-1:0];
        end else if (idle && MDOp == OP_MTHI) begin
            hi_nxt = A;
        end else if (idle && MDOp == OP_MTLO) begin
            lo_nxt = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            count <= count_nxt;
            Busy  <= (count_nxt != '0);
            HI    <= hi_nxt;
            LO    <= lo_nxt;
        end
    end

    // Pending result holds data only; the cleared counter is what cancels a commit.
    always_ff @(posedge clk) begin
        if (start) begin
            pend    <= res_nxt;
            pend_wr <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters; honours MD_MADD_EN).
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOp = op; A = a; B = b;
        step();
        MDOp = 4'd0;
    endtask

    // Counts sampled cycles with Busy high, starting from the current sample.
    task automatic busy_len(input string tag, input int base, input int exp);
        int n;
        n = base;
        for (int i = 0; i < 40 && Busy; i++) begin
            n++;
            step();
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; MDOp = 4'd0; A = '0; B = '0;
        step(); step();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b0;

        issue(4'b0001, 32'hFFFFFFFF, 32'h00000002);
        check("mult_busy_on", {31'd0, Busy}, 32'd1);
        check("mult_hi_hold", HI, 32'd0);
        busy_len("mult_len", 0, 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFE);

        issue(4'b0010, 32'hFFFFFFFF, 32'h00000002);
        busy_len("multu_len", 0, 5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);

        issue(4'b0011, 32'hFFFFFFF9, 32'd2);
        check("div_lo_hold", LO, 32'hFFFFFFFE);
        busy_len("div_len", 0, 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        issue(4'b0100, 32'd7, 32'd2);
        busy_len("divu_len", 0, 10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        issue(4'b0011, 32'h80000000, 32'hFFFFFFFF);
        busy_len("divmin_len", 0, 10);
        check("divmin_lo", LO, 32'h80000000);
        check("divmin_hi", HI, 32'd0);

        issue(4'b0101, 32'h12345678, 32'd0);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_hi", HI, 32'h12345678);
        issue(4'b0110, 32'h9ABCDEF0, 32'd0);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_hi_keep", HI, 32'h12345678);

        issue(4'b0100, 32'd5, 32'd0);
        busy_len("div0_len", 0, 10);
        check("div0_hi", HI, 32'h12345678);
        check("div0_lo", LO, 32'h9ABCDEF0);

        issue(4'b0001, 32'd3, 32'd4);
        MDOp = 4'b0110; A = 32'hDEADBEEF;
        step();
        MDOp = 4'b0100; A = 32'd9; B = 32'd2;
        step();
        MDOp = 4'd0;
        check("ign_lo_hold", LO, 32'h9ABCDEF0);
        busy_len("ign_len", 2, 5);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd12);
        step();
        check("ign_no_restart", {31'd0, Busy}, 32'd0);

        issue(4'b0101, 32'h00000055, 32'd0);
        issue(4'b0001, 32'd3, 32'd4);
        step(); step();
        check("abort_busy_pre", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("abort_late_busy", {31'd0, Busy}, 32'd0);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        issue(4'b0101, 32'd0, 32'd0);
        issue(4'b0110, 32'hFFFFFFFF, 32'd0);
        issue(4'b1000, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        check("maddu_busy_on", {31'd0, Busy}, 32'd1);
        busy_len("maddu_len", 0, 5);
        check("maddu_hi", HI, 32'd1);
        check("maddu_lo", LO, 32'd0);
`else
        check("maddu_busy_off", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("maddu_busy_late", {31'd0, Busy}, 32'd0);
        check("maddu_hi", HI, 32'd0);
        check("maddu_lo", LO, 32'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
